// File: rtl/key_event_decoder.sv
//------------------------------------------------------------------------------
// key_event_decoder
//
// Classifies debounced key activity into short-press, long-press, double-click
// and optional auto-repeat events for the front-panel menu logic. The block
// consumes the key_flag/key_state pair from the debounce filter. All timing
// derives from an internal 1 ms tick.
//
// Parameters:
//   TICK_DIV   clocks per 1 ms tick (1..65536)
//   LONG_MS    hold time in ms that qualifies a long press (2..65535)
//   DCLICK_MS  max release-to-second-press gap in ms for a double click (2..65535)
//   REPEAT_MS  auto-repeat period in ms while held after a long press (2..65535)
//
// Ports:
//   Clk           in   system clock
//   Rst_n         in   asynchronous active-low reset
//   key_flag      in   one-cycle strobe: a debounced edge occurred
//   key_state     in   debounced level, valid with key_flag (0 pressed, 1 released)
//   short_press   out  one-cycle pulse: single click completed
//   long_press    out  one-cycle pulse: hold reached LONG_MS
//   double_click  out  one-cycle pulse: second press within DCLICK_MS
//   key_repeat    out  one-cycle pulse every REPEAT_MS during a long hold
//   pressing      out  level: key is in a pressed/held state
//
// Build option:
//   KEY_REPEAT_EN  when defined, HELD issues key_repeat every REPEAT_MS.
//                  When undefined, key_repeat is tied low, the repeat timer
//                  is removed and HELD waits only for release.
//
// Output timing: decisions are taken on the edge that updates the state
// register; every output is registered once more from there, so pulses and
// pressing appear one clock after the state change.
//------------------------------------------------------------------------------
module key_event_decoder #(
  parameter int unsigned TICK_DIV  = 50_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_repeat,
  output logic pressing
);

  // Terminal counts for the prescaler and the per-state timeouts.
  localparam logic [15:0] TickLast   = 16'(TICK_DIV - 1);
  localparam logic [15:0] LongLast   = 16'(LONG_MS - 1);
  localparam logic [15:0] DclickLast = 16'(DCLICK_MS - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [15:0] RepeatLast = 16'(REPEAT_MS - 1);
`endif

  // One-hot state encoding; any other code is treated as illegal.
  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    PRESSED  = 5'b00010,
    WAIT2    = 5'b00100,
    PRESSED2 = 5'b01000,
    HELD     = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] prescaler_q, prescaler_d;
  logic [15:0] msCnt_q, msCnt_d;

  logic        shortEvt_q, shortEvt_d;
  logic        longEvt_q, longEvt_d;
  logic        dclickEvt_q, dclickEvt_d;
`ifdef KEY_REPEAT_EN
  logic        repeatEvt_q, repeatEvt_d;
`endif

  logic        pressEvt;
  logic        releaseEvt;
  logic        tick;
  logic        clearTimer;
  logic        timerRun;
  logic        toLong;
  logic        toDclick;
`ifdef KEY_REPEAT_EN
  logic        toRepeat;
`endif

  // Debounced edge decode: key_state is only meaningful alongside key_flag.
  assign pressEvt   = key_flag & ~key_state;
  assign releaseEvt = key_flag &  key_state;

  // The ms counter holds N-1 during the last tick period of an N ms window,
  // so a timeout lands exactly N*TICK_DIV clocks after state entry.
  assign tick     = (prescaler_q == TickLast);
  assign toLong   = tick && (msCnt_q == LongLast);
  assign toDclick = tick && (msCnt_q == DclickLast);
`ifdef KEY_REPEAT_EN
  assign toRepeat = tick && (msCnt_q == RepeatLast);
`endif

  // IDLE never times out; without auto-repeat neither does HELD, so the
  // timebase is parked at zero there.
`ifdef KEY_REPEAT_EN
  assign timerRun = (state_q != IDLE);
`else
  assign timerRun = (state_q != IDLE) && (state_q != HELD);
`endif

  // Next-state and event decision. Key events are tested before timeouts so
  // a coincident timeout is dropped. Every transition restarts the timebase.
  always_comb begin
    state_d     = state_q;
    clearTimer  = 1'b0;
    shortEvt_d  = 1'b0;
    longEvt_d   = 1'b0;
    dclickEvt_d = 1'b0;
`ifdef KEY_REPEAT_EN
    repeatEvt_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pressEvt) begin
          state_d    = PRESSED;
          clearTimer = 1'b1;
        end
      end
      PRESSED: begin
        if (releaseEvt) begin
          state_d    = WAIT2;
          clearTimer = 1'b1;
        end else if (toLong) begin
          longEvt_d  = 1'b1;
          state_d    = HELD;
          clearTimer = 1'b1;
        end
      end
      WAIT2: begin
        if (pressEvt) begin
          state_d    = PRESSED2;
          clearTimer = 1'b1;
        end else if (toDclick) begin
          shortEvt_d = 1'b1;
          state_d    = IDLE;
          clearTimer = 1'b1;
        end
      end
      PRESSED2: begin
        // A long second press still counts as a double click, never a long press.
        if (releaseEvt) begin
          dclickEvt_d = 1'b1;
          state_d     = IDLE;
          clearTimer  = 1'b1;
        end else if (toLong) begin
          dclickEvt_d = 1'b1;
          state_d     = HELD;
          clearTimer  = 1'b1;
        end
      end
      HELD: begin
        if (releaseEvt) begin
          state_d    = IDLE;
          clearTimer = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else if (toRepeat) begin
          repeatEvt_d = 1'b1;
          clearTimer  = 1'b1;
        end
`endif
      end
      default: begin
        state_d    = IDLE;
        clearTimer = 1'b1;
      end
    endcase
  end

  // Prescaler and ms counter: restart on transitions, advance otherwise.
  // The assertion flags out-of-range configurations in simulation.
  always_comb begin
    assert (TICK_DIV >= 1 && TICK_DIV <= 65536 &&
            LONG_MS >= 2 && LONG_MS <= 65535 &&
            DCLICK_MS >= 2 && DCLICK_MS <= 65535 &&
            REPEAT_MS >= 2 && REPEAT_MS <= 65535);
    prescaler_d = prescaler_q;
    msCnt_d     = msCnt_q;
    if (clearTimer || !timerRun) begin
      prescaler_d = '0;
      msCnt_d     = '0;
    end else if (tick) begin
      prescaler_d = '0;
      msCnt_d     = msCnt_q + 16'd1;
    end else begin
      prescaler_d = prescaler_q + 16'd1;
    end
  end

  // State, timebase and event decision registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      msCnt_q     <= '0;
      shortEvt_q  <= 1'b0;
      longEvt_q   <= 1'b0;
      dclickEvt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      msCnt_q     <= msCnt_d;
      shortEvt_q  <= shortEvt_d;
      longEvt_q   <= longEvt_d;
      dclickEvt_q <= dclickEvt_d;
    end
  end

  // Output stage: pulses and pressing follow the state register by one clock.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      pressing     <= 1'b0;
    end else begin
      short_press  <= shortEvt_q;
      long_press   <= longEvt_q;
      double_click <= dclickEvt_q;
      pressing     <= (state_q == PRESSED) || (state_q == PRESSED2) ||
                      (state_q == HELD);
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat decision and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      repeatEvt_q <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      repeatEvt_q <= repeatEvt_d;
      key_repeat  <= repeatEvt_q;
    end
  end
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
//------------------------------------------------------------------------------
// tb_key_event_decoder
//
// Drives key_flag/key_state schedules into key_event_decoder with small timing
// parameters and compares every cycle against an event/deadline model, plus
// directed timing checks for the documented scenarios. Works with and without
// KEY_REPEAT_EN.
//------------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam int TD   = 10;
  localparam int LMS  = 20;
  localparam int DMS  = 5;
  localparam int RMS  = 4;
  localparam int MAXT = 4000;

  localparam int EV_NONE  = 0;
  localparam int EV_PRESS = 1;
  localparam int EV_REL   = 2;

  // Bit positions of the observed vector.
  localparam int B_SHORT  = 0;
  localparam int B_LONG   = 1;
  localparam int B_DCLICK = 2;
  localparam int B_RPT    = 3;
  localparam int B_PRESS  = 4;

  // Behavioural key modes of the reference model.
  localparam int M_IDLE  = 0;
  localparam int M_DOWN1 = 1;
  localparam int M_GAP   = 2;
  localparam int M_DOWN2 = 3;
  localparam int M_HOLD  = 4;

  logic Clk;
  logic Rst_n;
  logic key_flag;
  logic key_state;
  logic short_press;
  logic long_press;
  logic double_click;
  logic key_repeat;
  logic pressing;

  int checks;
  int errors;
  int cyc;

  int         keyEv[MAXT];
  logic [4:0] obs[MAXT];
  logic [4:0] expVec[MAXT];

  key_event_decoder #(
    .TICK_DIV (TD),
    .LONG_MS  (LMS),
    .DCLICK_MS(DMS),
    .REPEAT_MS(RMS)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .key_flag    (key_flag),
    .key_state   (key_state),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .key_repeat  (key_repeat),
    .pressing    (pressing)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Edge counter since reset release: edge k makes cyc == k.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyReset();
    Rst_n     = 1'b0;
    key_flag  = 1'b0;
    key_state = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic clearStim();
    for (int i = 0; i < MAXT; i++) begin
      keyEv[i]  = EV_NONE;
      obs[i]    = '0;
      expVec[i] = '0;
    end
  endtask

  // Starts on a negedge with cyc==0; records outputs at each negedge and
  // drives the flag that the next posedge (edge c+1) samples.
  task automatic applyStimulus(input int len);
    for (int c = 0; c <= len; c++) begin
      obs[c] = {pressing, key_repeat, double_click, long_press, short_press};
      if (keyEv[c + 1] != EV_NONE) begin
        key_flag  = 1'b1;
        key_state = (keyEv[c + 1] == EV_REL);
      end else begin
        key_flag  = 1'b0;
        key_state = (($urandom & 1) != 0);
      end
      @(negedge Clk);
    end
    key_flag = 1'b0;
  endtask

  // Reference model: tracks the key mode and the edge at which it was
  // entered; a timeout is due N*TD edges after entry. The outputs observed
  // after edge e reflect the decisions and mode of edge e-1.
  task automatic runModel(input int len);
    int mode;
    int entry;
    int age;
    logic [3:0] pend;
    mode = M_IDLE;
    entry = 0;
    pend = '0;
    expVec[0] = '0;
    for (int e = 1; e <= len; e++) begin
      expVec[e] = {(mode == M_DOWN1 || mode == M_DOWN2 || mode == M_HOLD), pend};
      pend = '0;
      age = e - entry;
      case (mode)
        M_IDLE:
          if (keyEv[e] == EV_PRESS) begin mode = M_DOWN1; entry = e; end
        M_DOWN1:
          if (keyEv[e] == EV_REL) begin mode = M_GAP; entry = e; end
          else if (age == LMS * TD) begin pend[B_LONG] = 1'b1; mode = M_HOLD; entry = e; end
        M_GAP:
          if (keyEv[e] == EV_PRESS) begin mode = M_DOWN2; entry = e; end
          else if (age == DMS * TD) begin pend[B_SHORT] = 1'b1; mode = M_IDLE; entry = e; end
        M_DOWN2:
          if (keyEv[e] == EV_REL) begin pend[B_DCLICK] = 1'b1; mode = M_IDLE; entry = e; end
          else if (age == LMS * TD) begin pend[B_DCLICK] = 1'b1; mode = M_HOLD; entry = e; end
        default:
          if (keyEv[e] == EV_REL) begin mode = M_IDLE; entry = e; end
`ifdef KEY_REPEAT_EN
          else if (age == RMS * TD) begin pend[B_RPT] = 1'b1; entry = e; end
`endif
      endcase
    end
  endtask

  function automatic int countBit(input int b, input int len);
    int n = 0;
    for (int t = 0; t <= len; t++) if (obs[t][b] === 1'b1) n++;
    return n;
  endfunction

  function automatic int firstBit(input int b, input int len);
    for (int t = 0; t <= len; t++) if (obs[t][b] === 1'b1) return t;
    return -1;
  endfunction

  task automatic test_reset();
    Rst_n = 1'b0;
    key_flag = 1'b0;
    key_state = 1'b1;
    #12;
    checks++;
    if ({pressing, key_repeat, double_click, long_press, short_press} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {pressing, key_repeat, double_click, long_press, short_press}, 5'b0);
    end
    applyReset();
    clearStim();
    applyStimulus(40);
    runModel(40);
    for (int t = 0; t <= 40; t++) begin
      checks++;
      if (obs[t] !== expVec[t]) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", t, obs[t], expVec[t]);
      end
    end
  endtask

  task automatic test_single_click();
    applyReset();
    clearStim();
    keyEv[5]  = EV_PRESS;
    keyEv[35] = EV_REL;
    applyStimulus(200);
    runModel(200);
    for (int t = 0; t <= 200; t++) begin
      checks++;
      if (obs[t] !== expVec[t]) begin
        errors++;
        $display("[TB] FAIL single_click cycle %0d: got %b expected %b", t, obs[t], expVec[t]);
      end
    end
    checks++;
    if (firstBit(B_SHORT, 200) != 35 + DMS * TD + 1) begin
      errors++;
      $display("[TB] FAIL single_click_time: got %0d expected %0d",
               firstBit(B_SHORT, 200), 35 + DMS * TD + 1);
    end
    checks++;
    if (countBit(B_LONG, 200) + countBit(B_DCLICK, 200) + countBit(B_RPT, 200) != 0) begin
      errors++;
      $display("[TB] FAIL single_click_other: got %0d other pulses expected 0",
               countBit(B_LONG, 200) + countBit(B_DCLICK, 200) + countBit(B_RPT, 200));
    end
  endtask

  task automatic test_long_hold();
    int expRpt;
`ifdef KEY_REPEAT_EN
    expRpt = (505 - (5 + LMS * TD) - 1) / (RMS * TD);
`else
    expRpt = 0;
`endif
    applyReset();
    clearStim();
    keyEv[5]   = EV_PRESS;
    keyEv[505] = EV_REL;
    applyStimulus(600);
    runModel(600);
    for (int t = 0; t <= 600; t++) begin
      checks++;
      if (obs[t] !== expVec[t]) begin
        errors++;
        $display("[TB] FAIL long_hold cycle %0d: got %b expected %b", t, obs[t], expVec[t]);
      end
    end
    checks++;
    if (firstBit(B_LONG, 600) != 5 + LMS * TD + 1) begin
      errors++;
      $display("[TB] FAIL long_press_time: got %0d expected %0d", firstBit(B_LONG, 600), 5 + LMS * TD + 1);
    end
    checks++;
    if (countBit(B_RPT, 600) != expRpt) begin
      errors++;
      $display("[TB] FAIL repeat_count: got %0d expected %0d", countBit(B_RPT, 600), expRpt);
    end
`ifdef KEY_REPEAT_EN
    checks++;
    if (firstBit(B_RPT, 600) != 5 + (LMS + RMS) * TD + 1) begin
      errors++;
      $display("[TB] FAIL repeat_first: got %0d expected %0d", firstBit(B_RPT, 600), 5 + (LMS + RMS) * TD + 1);
    end
`endif
    checks++;
    if (obs[505][B_PRESS] !== 1'b1 || obs[506][B_PRESS] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pressing_fall: got %b%b expected 10", obs[505][B_PRESS], obs[506][B_PRESS]);
    end
  endtask

  task automatic test_double_click();
    applyReset();
    clearStim();
    keyEv[5]  = EV_PRESS;
    keyEv[25] = EV_REL;
    keyEv[55] = EV_PRESS;
    keyEv[75] = EV_REL;
    applyStimulus(200);
    runModel(200);
    for (int t = 0; t <= 200; t++) begin
      checks++;
      if (obs[t] !== expVec[t]) begin
        errors++;
        $display("[TB] FAIL double_click cycle %0d: got %b expected %b", t, obs[t], expVec[t]);
      end
    end
    checks++;
    if (firstBit(B_DCLICK, 200) != 76 || countBit(B_DCLICK, 200) != 1 || countBit(B_SHORT, 200) != 0) begin
      errors++;
      $display("[TB] FAIL double_click_pulse: got at %0d count %0d short %0d expected at 76 count 1 short 0",
               firstBit(B_DCLICK, 200), countBit(B_DCLICK, 200), countBit(B_SHORT, 200));
    end
  endtask

  task automatic test_gap_boundary();
    // Second press on the timeout edge itself.
    applyReset();
    clearStim();
    keyEv[5]  = EV_PRESS;
    keyEv[25] = EV_REL;
    keyEv[25 + DMS * TD] = EV_PRESS;
    keyEv[95] = EV_REL;
    applyStimulus(200);
    runModel(200);
    for (int t = 0; t <= 200; t++) begin
      checks++;
      if (obs[t] !== expVec[t]) begin
        errors++;
        $display("[TB] FAIL gap_on_edge cycle %0d: got %b expected %b", t, obs[t], expVec[t]);
      end
    end
    checks++;
    if (countBit(B_DCLICK, 200) != 1 || countBit(B_SHORT, 200) != 0) begin
      errors++;
      $display("[TB] FAIL gap_on_edge_pulses: got dclick %0d short %0d expected 1 0",
               countBit(B_DCLICK, 200), countBit(B_SHORT, 200));
    end
    // Second press one cycle late.
    applyReset();
    clearStim();
    keyEv[5]  = EV_PRESS;
    keyEv[25] = EV_REL;
    keyEv[26 + DMS * TD] = EV_PRESS;
    keyEv[96] = EV_REL;
    applyStimulus(200);
    runModel(200);
    for (int t = 0; t <= 200; t++) begin
      checks++;
      if (obs[t] !== expVec[t]) begin
        errors++;
        $display("[TB] FAIL gap_late cycle %0d: got %b expected %b", t, obs[t], expVec[t]);
      end
    end
    checks++;
    if (firstBit(B_SHORT, 200) != 76 || countBit(B_SHORT, 200) != 2 || obs[77][B_PRESS] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gap_late_pulses: got short at %0d count %0d pressing %b expected 76 2 1",
               firstBit(B_SHORT, 200), countBit(B_SHORT, 200), obs[77][B_PRESS]);
    end
  endtask

  task automatic test_reset_mid_hold();
    applyReset();
    clearStim();
    keyEv[5] = EV_PRESS;
    applyStimulus(155);
    runModel(155);
    for (int t = 0; t <= 155; t++) begin
      checks++;
      if (obs[t] !== expVec[t]) begin
        errors++;
        $display("[TB] FAIL pre_reset cycle %0d: got %b expected %b", t, obs[t], expVec[t]);
      end
    end
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({pressing, key_repeat, double_click, long_press, short_press} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected %b",
               {pressing, key_repeat, double_click, long_press, short_press}, 5'b0);
    end
    applyReset();
    clearStim();
    keyEv[3] = EV_REL;
    applyStimulus(80);
    runModel(80);
    for (int t = 0; t <= 80; t++) begin
      checks++;
      if (obs[t] !== 5'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_release cycle %0d: got %b expected %b", t, obs[t], 5'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyReset();
    clearStim();
    keyEv[5]  = EV_PRESS;
    keyEv[6]  = EV_REL;
    keyEv[7]  = EV_PRESS;
    keyEv[8]  = EV_REL;
    keyEv[20] = EV_PRESS;
    keyEv[21] = EV_REL;
    applyStimulus(150);
    runModel(150);
    for (int t = 0; t <= 150; t++) begin
      checks++;
      if (obs[t] !== expVec[t]) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", t, obs[t], expVec[t]);
      end
    end
    checks++;
    if (obs[9][B_DCLICK] !== 1'b1 || firstBit(B_SHORT, 150) != 21 + DMS * TD + 1) begin
      errors++;
      $display("[TB] FAIL back_to_back_pulses: got dclick9 %b short at %0d expected 1 %0d",
               obs[9][B_DCLICK], firstBit(B_SHORT, 150), 21 + DMS * TD + 1);
    end
  endtask

  task automatic test_random();
    int t;
    int sel;
    int gap;
    bit down;
    for (int run = 0; run < 3; run++) begin
      applyReset();
      clearStim();
      t = 3;
      down = 1'b0;
      while (t < 2600) begin
        keyEv[t] = down ? EV_REL : EV_PRESS;
        down = !down;
        sel = $urandom_range(0, 5);
        case (sel)
          0: gap = $urandom_range(1, 10);
          1: gap = $urandom_range(DMS * TD - 5, DMS * TD + 5);
          2: gap = $urandom_range(LMS * TD - 5, LMS * TD + 5);
          3: gap = $urandom_range((LMS + RMS) * TD - 5, (LMS + 2 * RMS) * TD + 5);
          4: gap = $urandom_range(11, 60);
          default: gap = 1;
        endcase
        t += gap;
      end
      applyStimulus(3000);
      runModel(3000);
      for (int k = 0; k <= 3000; k++) begin
        checks++;
        if (obs[k] !== expVec[k]) begin
          errors++;
          $display("[TB] FAIL random run %0d cycle %0d: got %b expected %b", run, k, obs[k], expVec[k]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_click();
    test_long_hold();
    test_double_click();
    test_gap_boundary();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
